arm_fetch_unit: RTL and testbench
=================================

Name: arm_fetch_unit

Overview:
- Instruction fetch/prefetch stage directly upstream of the multicycle ARM controller and datapath.
- Generates sequential instruction-memory reads and buffers returned words in a small in-order queue.
- Presents the head word as instr (controller consumes instr[31:12]); the controller's IRWrite pulse pops it.
- Controller PCWrite/branch target redirects fetch and flushes stale words, including in-flight ones.

Parameters:
- DEPTH, 2, prefetch queue entries (power of two, >=2).
- MAX_OUT, 2, maximum outstanding un-responded memory requests (1..DEPTH).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  single clock; all state rises on posedge.
- reset  in  1  asynchronous, active-low (0 = reset asserted); release is synchronous to clk externally.
- imem_req  out  1  read request valid.
- imem_addr  out  32  word-aligned read address, [1:0]=00.
- imem_gnt  in  1  request accepted this cycle (req&&gnt = handshake).
- imem_rvalid  in  1  read data returning, in request order.
- imem_rdata  in  32  returned instruction word.
- instr  out  32  queue head instruction; 32'h0 when empty.
- instr_pc  out  32  address of head instruction; 32'h0 when empty.
- instr_valid  out  1  queue non-empty.
- ir_write  in  1  controller IRWrite; pops head when instr_valid=1.
- redirect  in  1  flush and restart fetch.
- redirect_pc  in  32  new fetch address; bits [1:0] forced to 00.
- fetch_err  out  1  sticky: imem_rvalid with no outstanding request.

Behaviour:
- Reset (reset=0): fetch_pc=RESET_PC, tail_pc=RESET_PC, queue empty, outstanding=0, discard=0, fetch_err=0, imem_req=0, instr_valid=0, instr=0, instr_pc=0.
- Credit rule: imem_req=1 iff reset=1, redirect=0, (count+outstanding-discard)<DEPTH, and outstanding<MAX_OUT. imem_addr=fetch_pc whenever imem_req=1.
- On req&&gnt: fetch_pc+=4 (32-bit wrap, FFFF_FFFC->0000_0000); outstanding+=1.
- On rvalid: outstanding-=1.
  - If discard>0: discard-=1 and the word is dropped.
  - Otherwise {rdata, tail_pc} is pushed, then tail_pc+=4.
- Push-to-visible latency is 1 cycle; no bypass. rvalid in cycle N gives instr_valid in cycle N+1.
- Pop: ir_write&&instr_valid removes the head; the next entry is visible the following cycle. ir_write with instr_valid=0 is ignored; the controller stalls on instr_valid.
- Simultaneous push and pop: both occur and count is unchanged. The credit rule guarantees a push never overflows.
- Redirect (highest priority):
  - Queue cleared; a same-cycle pop or push is discarded.
  - fetch_pc=tail_pc={redirect_pc[31:2],2'b00}.
  - discard = outstanding after this cycle's grant/response accounting, so a request granted in the redirect cycle is also dropped.
  - imem_req=0 in the redirect cycle; first new request next cycle.
  - Back-to-back redirects: the last one wins, and discard accumulates correctly.
- Protocol error: rvalid with outstanding=0 sets fetch_err (sticky until reset); the word is ignored and counters are unchanged.
- Reset mid-operation clears everything immediately and asynchronously. Responses to pre-reset requests are the memory's responsibility, and fetch_err may flag them.

Decomposition:
- Package arm_fetch_pkg holds:
  - fetch_entry_t struct {logic [31:0] instr; logic [31:0] pc}.
  - Constants WORD_BYTES=4 and default RESET_PC.
- One sub-module arm_fetch_queue holds the synchronous FIFO of fetch_entry_t:
  - Ports: push, pop, flush, head, count, empty, full.
  - Same async active-low reset.
- The credit and discard counters stay in arm_fetch_unit.

Test Plan:
- Cold start:
  - Stimulus: reset low 2 cycles then high; gnt=1 always; memory returns rdata=addr^32'hE000_0000 one cycle after grant; ir_write=0.
  - Response: requests to 0x0 then 0x4, then req=0 (queue full); instr=E000_0000, instr_pc=0.
- Streaming:
  - Stimulus: as cold start, with ir_write=1 every cycle after instr_valid.
  - Response: instr_pc sequence 0,4,8,C... with no gaps after warm-up and no overflow.
- Redirect with in-flight:
  - Stimulus: redirect=1, redirect_pc=0x103, while one request is outstanding.
  - Response: the stale response is dropped; the next imem_addr=0x100; the first visible instr_pc=0x100.
- Simultaneous redirect and ir_write and rvalid:
  - Response: queue empty next cycle; discard accounting correct; no word from the old stream ever appears.
- Variable latency:
  - Stimulus: gnt random 50%, response delay 0-3 cycles.
  - Response: outstanding never exceeds MAX_OUT; count never exceeds DEPTH; order preserved.
- Errors and wrap:
  - rvalid with no request -> fetch_err=1 and it stays set.
  - redirect_pc=FFFF_FFFC -> next addresses FFFF_FFFC then 0000_0000.
  - Async reset mid-stream -> all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/arm_fetch_pkg.sv
// rtl/arm_fetch_pkg.sv - shared types and constants for the ARM instruction fetch stage
package arm_fetch_pkg;

  localparam int          WORD_BYTES       = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/arm_fetch_queue.sv
// rtl/arm_fetch_queue.sv - in-order prefetch FIFO of fetched words with their addresses
module arm_fetch_queue
  import arm_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t    mem_q [DEPTH];
  fetch_entry_t    mem_d [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/arm_fetch_unit.sv
// rtl/arm_fetch_unit.sv - credit-limited sequential instruction prefetch with redirect flush
module arm_fetch_unit
  import arm_fetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter int          MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        ir_write,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_err
);

  localparam int          CW   = $clog2(DEPTH) + 1;
  localparam logic [31:0] STEP = 32'(WORD_BYTES);

  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  tail_pc_q, tail_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic          fetch_err_q, fetch_err_d;

  logic [CW-1:0] q_count;
  logic          q_empty, q_full, q_push, q_pop;
  fetch_entry_t  q_head, q_push_data;
  logic          grant, resp, drop;
  logic [CW:0]   credit_used;

  arm_fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst_n     (reset),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .flush     (redirect),
    .head      (q_head),
    .count     (q_count),
    .empty     (q_empty),
    .full      (q_full)
  );

  always_comb begin
    // Words already queued plus live (non-discarded) requests must fit in the queue.
    credit_used = {1'b0, q_count} + {1'b0, outstanding_q} - {1'b0, discard_q};
    imem_req    = reset && !redirect && (credit_used < (CW+1)'(DEPTH))
                  && (outstanding_q < CW'(MAX_OUT));
    imem_addr   = fetch_pc_q;
    grant       = imem_req && imem_gnt;
    resp        = imem_rvalid && (outstanding_q != '0);
    drop        = resp && (discard_q != '0);
    q_pop       = ir_write && !q_empty && !redirect;
    q_push      = resp && !drop && !redirect && (!q_full || q_pop);
    q_push_data.instr = imem_rdata;
    q_push_data.pc    = tail_pc_q;

    fetch_pc_d    = grant  ? fetch_pc_q + STEP : fetch_pc_q;
    tail_pc_d     = q_push ? tail_pc_q + STEP  : tail_pc_q;
    outstanding_d = outstanding_q + CW'(grant) - CW'(resp);
    discard_d     = discard_q - CW'(drop);
    fetch_err_d   = fetch_err_q || (imem_rvalid && (outstanding_q == '0));

    if (redirect) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      tail_pc_d  = redirect_pc & 32'hFFFF_FFFC;
      discard_d  = outstanding_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      tail_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      fetch_err_q   <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      tail_pc_q     <= tail_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      fetch_err_q   <= fetch_err_d;
    end
  end

  assign instr_valid = !q_empty;
  assign instr       = q_empty ? 32'h0 : q_head.instr;
  assign instr_pc    = q_empty ? 32'h0 : q_head.pc;
  assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_arm_fetch_unit.sv
// tb/tb_arm_fetch_unit.sv - randomized bench for arm_fetch_unit against a queue-based reference model
module tb_arm_fetch_unit;

  localparam int DEPTH   = 2;
  localparam int MAX_OUT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        ir_write = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        fetch_err;

  always #5 clk = ~clk;

  arm_fetch_unit #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .ir_write    (ir_write),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetch_err   (fetch_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct { logic [31:0] addr; bit stale; } infl_t;
  typedef struct { logic [31:0] addr; int ready; } memreq_t;

  logic [31:0] m_vis[$];
  infl_t       m_infl[$];
  logic [31:0] m_fetch_pc;
  bit          m_err;

  memreq_t     mem[$];
  int          gnt_pct = 100, dmin = 0, dmax = 0, ir_pct = 0, redir_pct = 0;
  bit          rst_next = 1'b0, redir_now = 1'b0, spur_now = 1'b0, spur_cyc = 1'b0;
  bit          redir_on_rv = 1'b0, redir_hit = 1'b0;
  logic [31:0] redir_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hE000_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int live_count();
    int s = 0;
    foreach (m_infl[i]) if (!m_infl[i].stale) s++;
    return s;
  endfunction

  function automatic bit exp_req();
    return reset && !redirect && (m_vis.size() + live_count() < DEPTH) && (m_infl.size() < MAX_OUT);
  endfunction

  task automatic model_reset();
    m_vis.delete();
    m_infl.delete();
    m_fetch_pc = 32'h0;
    m_err      = 1'b0;
  endtask

  task automatic drive();
    cyc++;
    reset    = rst_next;
    imem_gnt = ($urandom_range(99) < gnt_pct);
    ir_write = ($urandom_range(99) < ir_pct);
    redirect = 1'b0;
    if (redir_now || ($urandom_range(99) < redir_pct)) begin
      redirect    = 1'b1;
      redirect_pc = redir_now ? redir_addr : $urandom;
      redir_now   = 1'b0;
    end
    spur_cyc = 1'b0;
    if (spur_now) begin
      imem_rvalid = 1'b1;
      imem_rdata  = $urandom;
      spur_cyc    = 1'b1;
      spur_now    = 1'b0;
    end else if (mem.size() > 0 && mem[0].ready <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mem[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    if (redir_on_rv && imem_rvalid && instr_valid) begin
      redirect    = 1'b1;
      ir_write    = 1'b1;
      redirect_pc = 32'h8000_0040;
      redir_on_rv = 1'b0;
      redir_hit   = 1'b1;
    end
  endtask

  task automatic compare_and_update();
    bit          er;
    bit          dopush;
    logic [31:0] pushpc;
    infl_t       e;
    er = exp_req();
    check("imem_req", imem_req, er);
    if (er) check("imem_addr", imem_addr, m_fetch_pc);
    check("instr_valid", instr_valid, m_vis.size() > 0);
    check("instr", instr, (m_vis.size() > 0) ? mem_word(m_vis[0]) : 32'h0);
    check("instr_pc", instr_pc, (m_vis.size() > 0) ? m_vis[0] : 32'h0);
    check("fetch_err", fetch_err, m_err);

    if (imem_rvalid && !spur_cyc && mem.size() > 0) void'(mem.pop_front());
    if (reset && imem_req && imem_gnt)
      mem.push_back('{imem_addr, cyc + 1 + int'($urandom_range(dmax, dmin))});

    if (!reset) begin
      model_reset();
      return;
    end
    dopush = 1'b0;
    pushpc = 32'h0;
    if (imem_rvalid) begin
      if (m_infl.size() == 0) begin
        m_err = 1'b1;
      end else begin
        e = m_infl.pop_front();
        if (!e.stale && !redirect) begin
          dopush = 1'b1;
          pushpc = e.addr;
        end
      end
    end
    if (ir_write && m_vis.size() > 0 && !redirect) void'(m_vis.pop_front());
    if (dopush) m_vis.push_back(pushpc);
    if (er && imem_gnt) begin
      m_infl.push_back('{m_fetch_pc, 1'b0});
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
    if (redirect) begin
      m_vis.delete();
      foreach (m_infl[i]) m_infl[i].stale = 1'b1;
      m_fetch_pc = redirect_pc & 32'hFFFF_FFFC;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    compare_and_update();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waitn;
    model_reset();

    // cold start
    rst_next = 1'b0; gnt_pct = 100; dmin = 0; dmax = 0; ir_pct = 0;
    repeat (2) step();
    check("rst_req", imem_req, 0);
    check("rst_instr", instr, 0);
    rst_next = 1'b1;
    step();
    check("cold_req0", imem_req, 1);
    check("cold_addr0", imem_addr, 32'h0);
    step();
    check("cold_req1", imem_req, 1);
    check("cold_addr1", imem_addr, 32'h4);
    step();
    check("cold_full_req", imem_req, 0);
    check("cold_instr", instr, 32'hE000_0000);
    check("cold_pc", instr_pc, 32'h0);
    repeat (4) step();
    check("cold_hold_pc", instr_pc, 32'h0);
    check("cold_hold_req", imem_req, 0);

    // streaming
    ir_pct = 100;
    repeat (40) step();

    // redirect with exactly one request in flight
    gnt_pct = 0;
    repeat (4) step();
    ir_pct = 0; gnt_pct = 100; dmin = 3; dmax = 3;
    step();
    gnt_pct = 0; redir_now = 1'b1; redir_addr = 32'h0000_0103;
    step();
    check("redir_req_low", imem_req, 0);
    gnt_pct = 100; dmin = 0; dmax = 0;
    step();
    check("redir_req", imem_req, 1);
    check("redir_addr", imem_addr, 32'h100);
    waitn = 0;
    while (!instr_valid && waitn < 20) begin
      step();
      waitn++;
    end
    check("redir_first_pc", instr_pc, 32'h100);

    // redirect coinciding with ir_write and a returning word
    ir_pct = 50; redir_on_rv = 1'b1; redir_hit = 1'b0; waitn = 0;
    while (!redir_hit && waitn < 50) begin
      step();
      waitn++;
    end
    check("simul_hit", redir_hit, 1);
    step();
    check("simul_empty", instr_valid, 0);

    // variable latency with random redirects
    gnt_pct = 50; dmin = 0; dmax = 3; ir_pct = 50; redir_pct = 5;
    repeat (2000) step();
    redir_pct = 0;

    // spurious response
    gnt_pct = 0; waitn = 0;
    while ((mem.size() > 0 || m_infl.size() > 0) && waitn < 50) begin
      step();
      waitn++;
    end
    check("drain_timeout", mem.size() + m_infl.size(), 0);
    spur_now = 1'b1;
    step();
    step();
    check("err_set", fetch_err, 1);
    repeat (5) step();
    check("err_sticky", fetch_err, 1);

    // address wrap
    gnt_pct = 100; ir_pct = 100; dmin = 0; dmax = 0;
    redir_now = 1'b1; redir_addr = 32'hFFFF_FFFF;
    step();
    check("wrap_req_low", imem_req, 0);
    step();
    check("wrap_req0", imem_req, 1);
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_req1", imem_req, 1);
    check("wrap_addr1", imem_addr, 32'h0);
    repeat (10) step();

    // asynchronous reset mid-stream
    @(posedge clk);
    #3;
    rst_next = 1'b0;
    reset    = 1'b0;
    #1;
    check("arst_req", imem_req, 0);
    check("arst_valid", instr_valid, 0);
    check("arst_instr", instr, 0);
    check("arst_pc", instr_pc, 0);
    check("arst_err", fetch_err, 0);
    model_reset();
    mem.delete();
    imem_rvalid = 1'b0;
    repeat (2) step();
    rst_next = 1'b1; gnt_pct = 50; dmax = 3; ir_pct = 50;
    repeat (30) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
